// File: rtl/rgb_fade_sequencer_if.sv
// Host/PWM-facing signal bundle for the RGB keyframe fade sequencer.
// master = register block and PWM side, slave = the sequencer itself.
interface rgb_fade_sequencer_if #(
  parameter int DUTY_W   = 12,
  parameter int NUM_KEYS = 8,
  parameter int HOLD_W   = 16
);
  localparam int KEY_W = $clog2(NUM_KEYS);

  logic                  enable;
  logic                  cfg_we;
  logic [KEY_W-1:0]      cfg_addr;
  logic [3*DUTY_W-1:0]   cfg_data;
  logic [KEY_W-1:0]      num_keys_m1;
  logic [DUTY_W-1:0]     step_size;
  logic [HOLD_W-1:0]     hold_periods;
  logic                  period_done;
  logic [DUTY_W-1:0]     duty_red;
  logic [DUTY_W-1:0]     duty_green;
  logic [DUTY_W-1:0]     duty_blue;
  logic                  duty_valid;
  logic [KEY_W-1:0]      key_idx;
  logic                  busy;

  modport master (
    output enable, cfg_we, cfg_addr, cfg_data, num_keys_m1, step_size,
           hold_periods, period_done,
    input  duty_red, duty_green, duty_blue, duty_valid, key_idx, busy
  );

  modport slave (
    input  enable, cfg_we, cfg_addr, cfg_data, num_keys_m1, step_size,
           hold_periods, period_done,
    output duty_red, duty_green, duty_blue, duty_valid, key_idx, busy
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Steps RGB PWM duties through a host-loaded keyframe table, ramping and holding on PWM period ticks.
// period_done in cycle N gives new duties plus a one-cycle duty_valid in cycle N+1.
module rgb_fade_sequencer #(
  parameter int DUTY_W   = 12,
  parameter int NUM_KEYS = 8,
  parameter int HOLD_W   = 16
) (
  input logic                clk,
  input logic                rst,
  rgb_fade_sequencer_if.slave seq
);
  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam logic [KEY_W-1:0]  KEY_ONE  = 1;
  localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
  localparam logic [DUTY_W-1:0] DUTY_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_W-1:0]     key_idx_q, key_idx_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [DUTY_W-1:0]    red_q, red_d;
  logic [DUTY_W-1:0]    green_q, green_d;
  logic [DUTY_W-1:0]    blue_q, blue_d;
  logic                 duty_valid_q, duty_valid_d;
  logic [3*DUTY_W-1:0]  table_q [NUM_KEYS];

  logic [3*DUTY_W-1:0]  tgt;
  logic [DUTY_W-1:0]    tgt_red, tgt_green, tgt_blue;
  logic [DUTY_W-1:0]    step_eff;
  logic [DUTY_W-1:0]    red_ramp, green_ramp, blue_ramp;

  // Moves clamp at the target, so neither direction can wrap.
  function automatic logic [DUTY_W-1:0] ramp_ch(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] trg,
    input logic [DUTY_W-1:0] stp
  );
    logic [DUTY_W-1:0] res;
    if (cur < trg) begin
      res = ((trg - cur) <= stp) ? trg : cur + stp;
    end else begin
      res = ((cur - trg) <= stp) ? trg : cur - stp;
    end
    return res;
  endfunction

  // Reads the registered table, so a same-cycle write lands after this tick.
  assign tgt       = table_q[key_idx_q];
  assign tgt_red   = tgt[3*DUTY_W-1:2*DUTY_W];
  assign tgt_green = tgt[2*DUTY_W-1:DUTY_W];
  assign tgt_blue  = tgt[DUTY_W-1:0];
  assign step_eff  = (seq.step_size == '0) ? DUTY_ONE : seq.step_size;

  assign red_ramp   = ramp_ch(red_q,   tgt_red,   step_eff);
  assign green_ramp = ramp_ch(green_q, tgt_green, step_eff);
  assign blue_ramp  = ramp_ch(blue_q,  tgt_blue,  step_eff);

  always_comb begin
    state_d      = state_q;
    key_idx_d    = key_idx_q;
    hold_cnt_d   = hold_cnt_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    duty_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seq.enable) begin
          key_idx_d = '0;
          state_d   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (seq.period_done) begin
          red_d        = red_ramp;
          green_d      = green_ramp;
          blue_d       = blue_ramp;
          duty_valid_d = (red_ramp != red_q) || (green_ramp != green_q) ||
                         (blue_ramp != blue_q);
          if ((red_ramp == tgt_red) && (green_ramp == tgt_green) &&
              (blue_ramp == tgt_blue)) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (seq.period_done) begin
          if (hold_cnt_q >= seq.hold_periods) begin
            // >= so a key count lowered below the current index still wraps.
            key_idx_d = (key_idx_q >= seq.num_keys_m1) ? '0 : key_idx_q + KEY_ONE;
            state_d   = ST_RAMP;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!seq.enable) begin
      state_d      = ST_IDLE;
      hold_cnt_d   = '0;
      key_idx_d    = key_idx_q;
      red_d        = red_q;
      green_d      = green_q;
      blue_d       = blue_q;
      duty_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_idx_q    <= '0;
      hold_cnt_q   <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      duty_valid_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      key_idx_q    <= key_idx_d;
      hold_cnt_q   <= hold_cnt_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      duty_valid_q <= duty_valid_d;
      if (seq.cfg_we) begin
        table_q[seq.cfg_addr] <= seq.cfg_data;
      end
    end
  end

  assign seq.duty_red   = red_q;
  assign seq.duty_green = green_q;
  assign seq.duty_blue  = blue_q;
  assign seq.duty_valid = duty_valid_q;
  assign seq.key_idx    = key_idx_q;
  assign seq.busy       = (state_q == ST_RAMP) || (state_q == ST_HOLD);
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for the RGB fade sequencer: each period tick that should change the
// duties pushes the expected triple; the duty_valid monitor pops and compares it.
module tb_rgb_fade_sequencer;
  localparam int DUTY_W   = 12;
  localparam int NUM_KEYS = 8;
  localparam int HOLD_W   = 16;

  logic clk;
  logic rst;

  int n_chk;
  int n_fail;
  logic [3*DUTY_W-1:0] sb_q[$];

  rgb_fade_sequencer_if #(.DUTY_W(DUTY_W), .NUM_KEYS(NUM_KEYS), .HOLD_W(HOLD_W)) bus ();

  rgb_fade_sequencer #(.DUTY_W(DUTY_W), .NUM_KEYS(NUM_KEYS), .HOLD_W(HOLD_W)) dut (
    .clk (clk),
    .rst (rst),
    .seq (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.duty_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", {bus.duty_red, bus.duty_green, bus.duty_blue}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("duty_rgb", {bus.duty_red, bus.duty_green, bus.duty_blue}, sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    bus.enable       = 1'b0;
    bus.period_done  = 1'b0;
    bus.cfg_we       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_key(input int idx, input logic [11:0] r, input logic [11:0] g,
                           input logic [11:0] b);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(idx);
    bus.cfg_data = {r, g, b};
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic set_cfg(input int nk, input int stp, input int hold);
    bus.num_keys_m1  = 3'(nk);
    bus.step_size    = 12'(stp);
    bus.hold_periods = 16'(hold);
  endtask

  task automatic start();
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop();
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One PWM period tick; chg says whether new duties {r,g,b} must appear next cycle.
  task automatic tick(input bit chg, input logic [11:0] r, input logic [11:0] g,
                      input logic [11:0] b);
    @(negedge clk);
    bus.period_done = 1'b1;
    if (chg) sb_q.push_back({r, g, b});
    @(negedge clk);
    bus.period_done = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_missing", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [11:0] kr(input int k); return 12'(100 * (k + 1)); endfunction
  function automatic logic [11:0] kg(input int k); return 12'(50 * (k + 1));  endfunction
  function automatic logic [11:0] kb(input int k); return 12'(4095 - k);      endfunction

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.enable       = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_data     = '0;
    bus.num_keys_m1  = '0;
    bus.step_size    = '0;
    bus.hold_periods = '0;
    bus.period_done  = 1'b0;

    // Reset state
    do_reset();
    @(posedge clk); #1;
    chk("rst_red", bus.duty_red, 0);
    chk("rst_green", bus.duty_green, 0);
    chk("rst_blue", bus.duty_blue, 0);
    chk("rst_valid", bus.duty_valid, 0);
    chk("rst_key", bus.key_idx, 0);
    chk("rst_busy", bus.busy, 0);

    // Single key, step 1024, hold 2
    write_key(0, 12'd4095, 12'd0, 12'd0);
    set_cfg(0, 1024, 2);
    start();
    chk("run_busy", bus.busy, 1);
    tick(1, 12'd1024, 12'd0, 12'd0);
    tick(1, 12'd2048, 12'd0, 12'd0);
    tick(1, 12'd3072, 12'd0, 12'd0);
    tick(1, 12'd4095, 12'd0, 12'd0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("hold_red", bus.duty_red, 4095);
    chk("hold_busy", bus.busy, 1);
    stop();
    chk("stop_busy", bus.busy, 0);

    // Two keys, full step, no hold: alternate every other tick
    write_key(0, 12'd100, 12'd200, 12'd300);
    write_key(1, 12'd0, 12'd0, 12'd0);
    set_cfg(1, 4095, 0);
    start();
    tick(1, 12'd100, 12'd200, 12'd300);
    chk("alt_key0", bus.key_idx, 0);
    tick(0, 0, 0, 0);
    chk("alt_key1", bus.key_idx, 1);
    tick(1, 12'd0, 12'd0, 12'd0);
    tick(0, 0, 0, 0);
    chk("alt_key_wrap", bus.key_idx, 0);
    tick(1, 12'd100, 12'd200, 12'd300);
    stop();

    // step_size 0 behaves as 1
    do_reset();
    write_key(0, 12'd3, 12'd0, 12'd0);
    set_cfg(0, 0, 5);
    start();
    tick(1, 12'd1, 12'd0, 12'd0);
    tick(1, 12'd2, 12'd0, 12'd0);
    tick(1, 12'd3, 12'd0, 12'd0);
    tick(0, 0, 0, 0);
    stop();

    // Disable coincident with period_done freezes outputs; re-enable resumes from there
    do_reset();
    write_key(0, 12'd4095, 12'd0, 12'd0);
    set_cfg(0, 1024, 0);
    start();
    tick(1, 12'd1024, 12'd0, 12'd0);
    tick(1, 12'd2048, 12'd0, 12'd0);
    @(negedge clk);
    bus.period_done = 1'b1;
    bus.enable      = 1'b0;
    @(negedge clk);
    bus.period_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("freeze_red", bus.duty_red, 2048);
    chk("freeze_busy", bus.busy, 0);
    start();
    tick(1, 12'd3072, 12'd0, 12'd0);
    tick(1, 12'd4095, 12'd0, 12'd0);

    // Overwrite target: coincident write uses old entry, then ramps back to 0
    do_reset();
    write_key(0, 12'd4095, 12'd0, 12'd0);
    set_cfg(0, 1024, 0);
    start();
    tick(1, 12'd1024, 12'd0, 12'd0);
    tick(1, 12'd2048, 12'd0, 12'd0);
    @(negedge clk);
    bus.period_done = 1'b1;
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    sb_q.push_back({12'd3072, 12'd0, 12'd0});
    @(negedge clk);
    bus.period_done = 1'b0;
    bus.cfg_we      = 1'b0;
    @(posedge clk); #1;
    chk("valid_missing", 64'(sb_q.size()), 64'd0);
    tick(1, 12'd2048, 12'd0, 12'd0);
    tick(1, 12'd1024, 12'd0, 12'd0);
    tick(1, 12'd0, 12'd0, 12'd0);
    stop();

    // Reset mid-HOLD clears outputs and table
    do_reset();
    write_key(0, 12'd500, 12'd600, 12'd700);
    set_cfg(0, 4095, 3);
    start();
    tick(1, 12'd500, 12'd600, 12'd700);
    tick(0, 0, 0, 0);
    @(negedge clk);
    rst        = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rgb", {bus.duty_red, bus.duty_green, bus.duty_blue}, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_key", bus.key_idx, 0);
    start();
    tick(0, 0, 0, 0);
    chk("cleared_table_red", bus.duty_red, 0);

    // Lower num_keys_m1 below key_idx: next advance wraps to 0
    do_reset();
    for (int k = 0; k < NUM_KEYS; k++) write_key(k, kr(k), kg(k), kb(k));
    set_cfg(7, 4095, 0);
    start();
    for (int k = 0; k < 5; k++) begin
      tick(1, kr(k), kg(k), kb(k));
      tick(0, 0, 0, 0);
    end
    chk("key_at_5", bus.key_idx, 5);
    tick(1, kr(5), kg(5), kb(5));
    bus.num_keys_m1 = 3'd2;
    tick(0, 0, 0, 0);
    chk("key_wrap_low", bus.key_idx, 0);
    tick(1, kr(0), kg(0), kb(0));
    stop();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
